// File: rtl/arm_immediate_encoder_if.sv
// Request/response bundle for the ARM modified-immediate encoder.
// The master issues a constant and collects {found, rot, imm8}; the slave is the encoder.
interface arm_immediate_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [11:0] out_imm12;
  logic        busy;

  modport master (
    output in_valid,
    output in_value,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_found,
    input  out_imm12,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_found,
    output out_imm12,
    output busy
  );
endinterface

// File: rtl/arm_immediate_encoder.sv
// Iterative search for the smallest rotation that expresses a 32-bit constant
// as ROR(imm8, 2*rot); tests one rotation per clock behind valid/ready handshakes.
module arm_immediate_encoder (
  input  logic                    clk,
  input  logic                    reset,
  arm_immediate_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] value_q;
  logic [3:0]  rot_q;
  logic        found_q;
  logic [11:0] imm12_q;

  logic [4:0]  shift;
  logic [31:0] cand;
  logic        match;

  // Rotating the constant left by 2*rot undoes the extender's right rotate;
  // a shift of 32 on the right half yields zero, which covers rot 0.
  assign shift = {rot_q, 1'b0};
  assign cand  = (value_q << shift) | (value_q >> (6'd32 - {1'b0, shift}));
  assign match = (cand[31:8] == 24'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      value_q <= 32'd0;
      rot_q   <= 4'd0;
      found_q <= 1'b0;
      imm12_q <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            value_q <= bus.in_value;
            rot_q   <= 4'd0;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          // Ascending order guarantees the first hit is the minimal rotation.
          if (match) begin
            imm12_q <= {rot_q, cand[7:0]};
            found_q <= 1'b1;
            state   <= DONE;
          end else if (rot_q == 4'd15) begin
            imm12_q <= 12'h000;
            found_q <= 1'b0;
            state   <= DONE;
          end else begin
            rot_q <= rot_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == SEARCH);
  assign bus.out_found = found_q;
  assign bus.out_imm12 = imm12_q;

endmodule

// File: tb/tb_arm_immediate_encoder.sv
// Directed bench for arm_immediate_encoder: brute-force extender model plus
// literal expectations for result, latency, backpressure and mid-search reset.
module tb_arm_immediate_encoder;

  logic clk;
  logic reset;

  arm_immediate_encoder_if bus ();

  arm_immediate_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic        pending;
  logic        exp_found;
  logic [11:0] exp_imm12;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model works from the extender's side: try every imm8 at every rotation, smallest rotation first.
  function automatic void model_encode(input logic [31:0] v, output logic f, output logic [11:0] imm, output int lat);
    logic [63:0] dbl;
    logic [31:0] expanded;
    logic [7:0]  k8;
    logic [3:0]  r4;
    f   = 1'b0;
    imm = 12'h000;
    lat = 16;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 256; k++) begin
        k8       = k[7:0];
        dbl      = {24'd0, k8, 24'd0, k8} >> (2 * r);
        expanded = dbl[31:0];
        if (!f && expanded == v) begin
          r4  = r[3:0];
          f   = 1'b1;
          imm = {r4, k8};
          lat = r + 1;
        end
      end
    end
  endfunction

  // Every cycle: a pending request must be searching or presenting the model's result.
  always @(negedge clk) begin
    if (!reset) begin
      if (pending && bus.out_valid) begin
        check_output("cmp_found", {31'd0, bus.out_found}, {31'd0, exp_found});
        check_output("cmp_imm12", {20'd0, bus.out_imm12}, {20'd0, exp_imm12});
        check_output("cmp_in_ready_done", {31'd0, bus.in_ready}, 32'd0);
      end else if (pending) begin
        check_output("cmp_busy_search", {31'd0, bus.busy}, 32'd1);
      end else if (bus.out_valid) begin
        check_output("cmp_spurious_valid", {31'd0, bus.out_valid}, 32'd0);
      end
    end
  end

  task automatic accept(input logic [31:0] value);
    logic        mf;
    logic [11:0] mi;
    int          ml;
    int          waited;
    model_encode(value, mf, mi, ml);
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) check_output("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_value = value;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_found = mf;
    exp_imm12 = mi;
    pending   = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [31:0] value, input logic lit_found,
                                input logic [11:0] lit_imm12, input int lit_lat, input int hold);
    int lat;
    accept(value);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output($sformatf("latency_%08h", value), lat, lit_lat);
    check_output($sformatf("found_%08h", value), {31'd0, bus.out_found}, {31'd0, lit_found});
    check_output($sformatf("imm12_%08h", value), {20'd0, bus.out_imm12}, {20'd0, lit_imm12});
    for (int i = 0; i < hold; i++) begin
      bus.in_value = $urandom;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_output("hold_imm12", {20'd0, bus.out_imm12}, {20'd0, lit_imm12});
      check_output("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    pending = 1'b0;
    check_output("post_handshake_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("post_handshake_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    pending       = 1'b0;
    exp_found     = 1'b0;
    exp_imm12     = 12'h000;
    bus.in_valid  = 1'b0;
    bus.in_value  = 32'd0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    #12;
    check_output("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_output("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_output("reset_found", {31'd0, bus.out_found}, 32'd0);
    check_output("reset_imm12", {20'd0, bus.out_imm12}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    apply_stimulus(32'h000000FF, 1'b1, 12'h0FF, 1, 0);
    apply_stimulus(32'h3FC00000, 1'b1, 12'h5FF, 6, 0);
    apply_stimulus(32'hC000003F, 1'b1, 12'h1FF, 2, 0);
    apply_stimulus(32'h000000F0, 1'b1, 12'h0F0, 1, 0);
    apply_stimulus(32'h00000000, 1'b1, 12'h000, 1, 0);
    apply_stimulus(32'h00000101, 1'b0, 12'h000, 16, 0);
    apply_stimulus(32'h00000102, 1'b0, 12'h000, 16, 0);
    apply_stimulus(32'h00000104, 1'b1, 12'hF41, 16, 0);
    apply_stimulus(32'hFFFFFFFF, 1'b0, 12'h000, 16, 0);
    apply_stimulus(32'hFF000000, 1'b1, 12'h4FF, 5, 3);

    // Reset in the middle of an unencodable search drops the request.
    accept(32'h00000101);
    repeat (5) @(posedge clk);
    #1;
    reset   = 1'b1;
    pending = 1'b0;
    #1;
    check_output("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_output("midreset_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("postreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_output("postreset_busy", {31'd0, bus.busy}, 32'd0);
    apply_stimulus(32'hFF000000, 1'b1, 12'h4FF, 5, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
